ksa_sub_pipe: RTL and testbench

//  Pipelined Kogge-Stone subtractor: diff = a - b - bin, borrow-out bout.
//  It is the inverse-operation counterpart to the pipelined KSA adder.

---
 rtl/ksa_sub_pipe.sv | 112 +++++++++++
 tb/tb_ksa_sub_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor computing a - b - bin as a + ~b + ~bin.
// Every prefix level is registered, and a per-stage valid/ready chain lets the pipe stall and collapse bubbles.
module ksa_sub_pipe #(
  parameter int BITS   = 64,
  parameter int LEVELS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic            in_bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_diff,
  output logic            out_bout
);

  localparam int S = LEVELS + 2;

  function automatic logic [2*BITS-1:0] ks_level(input logic [BITS-1:0] g,
                                                 input logic [BITS-1:0] p,
                                                 input int span);
    logic [BITS-1:0] go;
    logic [BITS-1:0] po;
    go = g;
    po = p;
    for (int i = 0; i < BITS; i++) begin
      if (i >= span) begin
        go[i] = g[i] | (p[i] & g[i-span]);
        po[i] = p[i] & p[i-span];
      end
    end
    return {go, po};
  endfunction

  logic [S-1:0]    vld;
  logic [S-1:0]    vld_in;
  logic [S:0]      rdy;

  logic [BITS-1:0] h_p [LEVELS+1];
  logic [BITS-1:0] g_p [LEVELS+1];
  logic [BITS-1:0] p_p [LEVELS+1];
  logic [LEVELS:0] cin_p;

  logic [BITS-1:0] nb;
  logic [BITS-1:0] h0;
  logic [BITS-1:0] g0;

  // A stage can load when it is empty or its content moves on this cycle.
  always_comb begin
    logic r;
    r      = out_ready;
    rdy    = '0;
    rdy[S] = out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      r      = !vld[k] || r;
      rdy[k] = r;
    end
  end

  assign vld_in    = {vld[S-2:0], in_valid};
  assign in_ready  = rdy[0] && rst_n;
  assign out_valid = vld[S-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (rdy[k]) vld[k] <= vld_in[k];
      end
    end
  end

  // Carry-in is folded into bit 0's generate, so every prefix G[i] spans [i:-1].
  always_comb begin
    nb    = ~in_b;
    h0    = in_a ^ nb;
    g0    = in_a & nb;
    g0[0] = g0[0] | (h0[0] & ~in_bin);
  end

  always_ff @(posedge clk) begin
    if (rdy[0] && in_valid) begin
      h_p[0]   <= h0;
      g_p[0]   <= g0;
      p_p[0]   <= h0;
      cin_p[0] <= ~in_bin;
    end
    for (int k = 1; k <= LEVELS; k++) begin
      if (rdy[k] && vld[k-1]) begin
        {g_p[k], p_p[k]} <= ks_level(g_p[k-1], p_p[k-1], 1 << (k - 1));
        h_p[k]           <= h_p[k-1];
        cin_p[k]         <= cin_p[k-1];
      end
    end
  end

  // Output stage: sum bits and borrow (inverted carry-out).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_diff <= '0;
      out_bout <= 1'b0;
    end else if (rdy[S-1] && vld[S-2]) begin
      out_diff <= h_p[LEVELS] ^ {g_p[LEVELS][BITS-2:0], cin_p[LEVELS]};
      out_bout <= ~g_p[LEVELS][BITS-1];
    end
  end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Randomized bench for ksa_sub_pipe: a scoreboard of plain 65-bit arithmetic results,
// a handshake monitor on the falling edge, and directed boundary, stall and reset scenarios.
module tb_ksa_sub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_diff;
  logic        out_bout;

  ksa_sub_pipe #(.BITS(64), .LEVELS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_bout(out_bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        bo;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_out = 0;
  bit          chk_lat = 1'b0;
  int          rdy_mode = 0;
  bit          prev_stall = 1'b0;
  logic [64:0] prev_val;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Consumer: 0 = stall, 1 = always ready, 2 = random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: falling-edge values equal what the next rising edge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {out_valid, out_bout, out_diff}, {1'b1, prev_val});
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("spurious_out", 66'd1, 66'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {1'b0, out_bout, out_diff}, {1'b0, e.bo, e.d});
          if (chk_lat) chk("latency", 66'(cyc - e.acc), 66'd8);
        end
      end
      if (in_valid && in_ready) begin
        logic [64:0] r;
        exp_t e;
        r     = {1'b0, in_a} - {1'b0, in_b} - 65'(in_bin);
        e.d   = r[63:0];
        e.bo  = r[64];
        e.acc = cyc;
        sb.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = {out_bout, out_diff};
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic bin);
    bit took;
    in_a     = a;
    in_b     = b;
    in_bin   = bin;
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      if (t > 200) begin
        chk("send_timeout", 66'd0, 66'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 66'(sb.size()), 66'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int acc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_bin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 66'(out_valid), 66'd0);
    chk("rst_out_diff", 66'(out_diff), 66'd0);
    chk("rst_out_bout", 66'(out_bout), 66'd0);
    chk("rst_in_ready_low", 66'(in_ready), 66'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 66'(in_ready), 66'd1);
    chk("post_rst_out_valid", 66'(out_valid), 66'd0);

    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(64'd5, 64'd3, 1'b0);
    wait_drain();
    send(64'd0, 64'd1, 1'b0);
    send(64'd0, 64'd0, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
    send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    wait_drain();

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] a;
      a = rnd64();
      if ((i % 17) == 0) send(a, a, 1'($urandom_range(0, 1)));
      else               send(a, rnd64(), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    chk_lat = 1'b0;

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    acc      = 0;
    in_a     = rnd64();
    in_b     = rnd64();
    in_bin   = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit took;
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        acc++;
        in_a   = rnd64();
        in_b   = rnd64();
        in_bin = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    chk("stall_accepts", 66'(acc), 66'd8);
    chk("stall_in_ready", 66'(in_ready), 66'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) send(rnd64(), rnd64(), 1'($urandom_range(0, 1)));
    wait_drain();

    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(rnd64(), rnd64(), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 66'(out_valid), 66'd0);
    chk("midrst_out_diff", 66'(out_diff), 66'd0);
    chk("midrst_in_ready", 66'(in_ready), 66'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 66'(in_ready), 66'd1);
    n_out    = 0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_out_count", 66'(n_out), 66'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
